// File: rtl/lsu_master.sv
// lsu_master: load/store initiator with alignment check, lane steering and ack timeout.
module lsu_master #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_valid,
    output logic        cpu_ready,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_uext,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err_align,
    output logic        err_timeout,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          we_q, we_d, uext_q, uext_d, ea_q, ea_d, et_q, et_d;
    logic [1:0]    size_q, size_d;
    logic [31:0]   addr_q, addr_d, wd_q, wd_d, rdata_q, rdata_d;
    logic [3:0]    be_q, be_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ok;
    logic [31:0]   sh, ext;

    assign cpu_ready   = state_q == IDLE;
    assign done        = state_q == RESP;
    assign err_align   = done & ea_q;
    assign err_timeout = done & et_q;
    assign mem_req     = state_q == REQ;
    assign mem_we      = we_q;
    assign mem_addr    = {addr_q[31:2], 2'b00};
    assign mem_be      = be_q;
    assign mem_wdata   = wd_q;
    assign rdata       = rdata_q;

    always_comb begin
        ok = cpu_size == 2'b10 ? cpu_addr[1:0] == 2'b00 :
             cpu_size == 2'b01 ? !cpu_addr[0] : cpu_size == 2'b00;
        // halfword accesses are aligned, so a byte-granular shift also lands the half lane
        sh  = mem_rdata >> {addr_q[1:0], 3'b000};
        ext = size_q == 2'b00 ? (uext_q ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]}) :
              size_q == 2'b01 ? (uext_q ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]}) :
              mem_rdata;
        state_d = state_q;
        we_d    = we_q;
        uext_d  = uext_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        be_d    = be_q;
        ea_d    = ea_q;
        et_d    = et_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        if (state_q == IDLE && cpu_valid) begin
            we_d    = cpu_we;
            uext_d  = cpu_uext;
            size_d  = cpu_size;
            addr_d  = cpu_addr;
            be_d    = cpu_size == 2'b00 ? 4'b0001 << cpu_addr[1:0] :
                      cpu_size == 2'b01 ? 4'b0011 << cpu_addr[1:0] : 4'b1111;
            wd_d    = cpu_size == 2'b00 ? {4{cpu_wdata[7:0]}} :
                      cpu_size == 2'b01 ? {2{cpu_wdata[15:0]}} : cpu_wdata;
            ea_d    = !ok;
            et_d    = 1'b0;
            cnt_d   = '0;
            state_d = ok ? REQ : RESP;
            rdata_d = ok ? rdata_q : 32'b0;
        end else if (state_q == REQ) begin
            if (mem_ack) begin
                state_d = RESP;
                rdata_d = we_q ? rdata_q : ext;
            end else if (cnt_q == LAST) begin
                state_d = RESP;
                et_d    = 1'b1;
                rdata_d = 32'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            uext_q  <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'b0;
            wd_q    <= 32'b0;
            be_q    <= 4'b0;
            ea_q    <= 1'b0;
            et_q    <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= 32'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            uext_q  <= uext_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            be_q    <= be_d;
            ea_q    <= ea_d;
            et_q    <= et_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: doc/lsu_master.md
# lsu_master

Load/store initiator that sits between the CPU's memory stage and the word-addressed data memory. It accepts one byte, halfword or word access per transaction, checks alignment, and drives a word-aligned request with byte enables and lane-replicated write data. It holds the request until the memory acknowledges or a timeout expires. For loads, it extracts the addressed lane and sign- or zero-extends it before returning it to the pipeline with a one-cycle `done` pulse.

## Interface
- `TIMEOUT`, default 15: number of consecutive un-acknowledged request cycles before the access is aborted. Must be ≥1.

- `clk`  input  1  system clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `cpu_valid`  input  1  access request; sampled only while `cpu_ready`=1.
- `cpu_ready`  output  1  block idle and able to accept.
- `cpu_we`  input  1  1 = store, 0 = load.
- `cpu_size`  input  2  00 = byte, 01 = half, 10 = word, 11 = invalid.
- `cpu_uext`  input  1  load extension: 1 = zero-extend, 0 = sign-extend.
- `cpu_addr`  input  32  byte address.
- `cpu_wdata`  input  32  store data, right-justified.
- `done`  output  1  one-cycle completion pulse.
- `rdata`  output  32  extended load result.
- `err_align`  output  1  misaligned or invalid-size access; valid with `done` only.
- `err_timeout`  output  1  memory did not acknowledge; valid with `done` only.
- `mem_req`  output  1  memory request, held until acknowledged or timed out.
- `mem_we`  output  1  write strobe, qualified by `mem_req`.
- `mem_addr`  output  32  `{addr[31:2],2'b00}`.
- `mem_be`  output  4  byte enables.
- `mem_wdata`  output  32  lane-replicated store data.
- `mem_ack`  input  1  memory accepts the request; read data is valid in the same cycle.
- `mem_rdata`  input  32  memory read word.

## Operation
- States: IDLE, REQ, RESP. `cpu_ready` = (state==IDLE).
- IDLE, `cpu_valid`=1:
  - Latch we, size, uext, addr and wdata.
  - Alignment check: half requires addr[0]=0; word requires addr[1:0]=0; size 11 always fails.
  - Fail → RESP with align error. Pass → REQ, with the wait counter cleared.
- Byte enables:
  - Byte: `4'b0001<<addr[1:0]`.
  - Half: `4'b0011<<addr[1:0]`.
  - Word: `4'b1111`.
  - Enables are driven for loads as well.
- Write data:
  - Byte: `{4{wdata[7:0]}}`.
  - Half: `{2{wdata[15:0]}}`.
  - Word: wdata.
- REQ:
  - `mem_req`=1, and `mem_addr`, `mem_be`, `mem_we` and `mem_wdata` are stable from the latched values.
  - `mem_ack`=1 → for a load, select lane `mem_rdata[8*addr[1:0]+:8]` (byte) or `mem_rdata[16*addr[1]+:16]` (half) and extend per uext into `rdata`; go to RESP.
  - `mem_ack`=0 → increment the counter. When the counter is at TIMEOUT-1, go to RESP with timeout error.
  - Ack in the expiring cycle wins; no timeout is reported.
  - Counter width is ceil(log2(TIMEOUT+1)).
- RESP:
  - `done`=1 for exactly one cycle, with the error flags set as latched; then go to IDLE.
  - Any error forces `rdata`=0.
  - Stores leave `rdata` unchanged. `rdata` otherwise holds until the next load or error completion.
- `mem_req`=0 in IDLE and RESP. `mem_addr`, `mem_be`, `mem_we` and `mem_wdata` are don't-care when `mem_req`=0, but must not glitch during REQ.

## Timing
- Reset values (asserted asynchronously): state IDLE, `cpu_ready`=1, `done`=0, `rdata`=0, `err_align`=0, `err_timeout`=0, `mem_req`=0, `mem_we`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0, counter 0.
- Reset mid-REQ drops `mem_req` immediately. The aborted access produces no `done`.
- Latency from the accept edge:
  - `mem_req` is high in the next cycle.
  - With a zero-wait ack, `done` is high 2 cycles after accept.
  - For an align error, `done` is high 1 cycle after accept, and `mem_req` never asserts.
- Timeout: `mem_req` is high for exactly TIMEOUT cycles, then `done` pulses in the following cycle.
- Back-to-back throughput: the next accept is possible in the cycle after `done`. The minimum period is 3 cycles per access.
- `cpu_valid` while `cpu_ready`=0 is ignored. No inputs are queued.
- `err_align` and `err_timeout` are 0 whenever `done`=0.

## Test plan
- Sign-extended byte load: lb at addr 0x1003, `mem_rdata`=0x80123456, ack in the first REQ cycle → `mem_addr`=0x1000, `mem_be`=1000, `done` 2 cycles after accept, `rdata`=0xFFFFFF80.
- Zero-extended half load: lhu at addr 0x2002, `mem_rdata`=0xBEEF0000 → `mem_be`=1100, `rdata`=0x0000BEEF. Repeat as lh → `rdata`=0xFFFFBEEF.
- Byte store with wait states: sb at addr 0x5, `cpu_wdata`=0x12345678, `mem_ack` low for 3 cycles → `mem_addr`=0x4, `mem_be`=0010, `mem_wdata`=0x78787878, `mem_we`=1, all held stable for 4 cycles. `done` follows the ack by one cycle, and `rdata` is unchanged.
- Misaligned store: sw at addr 0x6; then size=11 at addr 0x0 → for each, no `mem_req`, `done`=1 and `err_align`=1 one cycle after accept, `rdata`=0.
- Timeout: TIMEOUT=4, `mem_ack` held 0 → `mem_req` high for exactly 4 cycles, then `done`=1 and `err_timeout`=1. Repeat with the ack arriving in the 4th cycle → no error.
- Reset mid-REQ: assert reset during REQ → `mem_req`=0 and `cpu_ready`=1 immediately, with no `done`. After release, a lw at 0x10 with `mem_rdata`=0xCAFEBABE returns 0xCAFEBABE.
